lcd_cmd_sequencer: RTL and testbench

//  Sequences writes to an HD44780-class character LCD in the wb_LCD path. Owns the E-strobe timing

---
 rtl/lcd_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780 write sequencer with power-up init and valid/ready byte interface
// Optional LCD_SEQ_CLR_WAIT_EN adds a CLR_WAIT state after clear/home instructions.
module lcd_cmd_sequencer #(
  parameter int TICK_DIV       = 500_000,
  parameter int POWERUP_TICKS  = 5,
  parameter int CLR_WAIT_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int MT = POWERUP_TICKS > CLR_WAIT_TICKS ? POWERUP_TICKS : CLR_WAIT_TICKS;
  localparam int TW = MT > 1 ? $clog2(MT) : 1;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_SETUP, INIT_PULSE, INIT_HOLD, IDLE, SETUP, PULSE, HOLD, CLR_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] ticks;
  logic [1:0]    idx;
  logic          phase_end;

  function automatic logic [7:0] rom(input logic [1:0] i);
    return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h06 : 8'h01;
  endfunction

  assign phase_end = cnt == CW'(TICK_DIV - 1);
  assign lcd_rw    = 1'b0;

`ifdef LCD_SEQ_CLR_WAIT_EN
  logic clr_cmd;
  assign clr_cmd = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02);
`endif

  // Phase-timed write sequencer: power-up wait, init ROM writes, then handshake-driven writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      ticks     <= '0;
      idx       <= '0;
      cmd_ready <= 1'b0;
      init_done <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      cnt <= phase_end ? '0 : cnt + 1'b1;
      case (state)
        PWR_WAIT: if (phase_end) begin
          ticks <= ticks + 1'b1;
          if (ticks == TW'(POWERUP_TICKS - 1)) begin
            state    <= INIT_SETUP;
            ticks    <= '0;
            lcd_data <= rom(idx);
          end
        end
        INIT_SETUP: if (phase_end) begin
          state <= INIT_PULSE;
          lcd_e <= 1'b1;
        end
        INIT_PULSE: if (phase_end) begin
          state <= INIT_HOLD;
          lcd_e <= 1'b0;
        end
        INIT_HOLD: if (phase_end) begin
          idx <= idx + 1'b1;
          if (idx == 2'd3) begin
`ifdef LCD_SEQ_CLR_WAIT_EN
            state <= CLR_WAIT;
`else
            state     <= IDLE;
            init_done <= 1'b1;
            cmd_ready <= 1'b1;
`endif
          end else begin
            state    <= INIT_SETUP;
            lcd_data <= rom(idx + 2'd1);
          end
        end
        IDLE: begin
          cnt <= '0;
          if (cmd_valid) begin
            state     <= SETUP;
            lcd_rs    <= cmd_rs;
            lcd_data  <= cmd_data;
            cmd_ready <= 1'b0;
          end
        end
        SETUP: if (phase_end) begin
          state <= PULSE;
          lcd_e <= 1'b1;
        end
        PULSE: if (phase_end) begin
          state <= HOLD;
          lcd_e <= 1'b0;
        end
        HOLD: if (phase_end) begin
`ifdef LCD_SEQ_CLR_WAIT_EN
          if (clr_cmd) state <= CLR_WAIT;
          else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
`else
          state     <= IDLE;
          cmd_ready <= 1'b1;
`endif
        end
`ifdef LCD_SEQ_CLR_WAIT_EN
        CLR_WAIT: if (phase_end) begin
          ticks <= ticks + 1'b1;
          if (ticks == TW'(CLR_WAIT_TICKS - 1)) begin
            ticks     <= '0;
            state     <= IDLE;
            cmd_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
`endif
        default: state <= PWR_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: directed + randomized checks of init, handshake timing, E strobe and reset abort
module tb_lcd_cmd_sequencer;
  localparam int TD = 4, P = 2, CWT = 2;
`ifdef LCD_SEQ_CLR_WAIT_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam int INIT_T = (P + 12 + (CLR_EN ? CWT : 0)) * TD;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic cmd_ready, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_cmd_sequencer #(.TICK_DIV(TD), .POWERUP_TICKS(P), .CLR_WAIT_TICKS(CWT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .init_done(init_done), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] got_q[$];
  int rise_q[$];
  logic prev_e = 1'b0;
  logic [8:0] prev_bus = '0;
  int hi = 0;
  logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic rs, input logic [7:0] d);
    return 3 * TD + ((CLR_EN && !rs && (d == 8'h01 || d == 8'h02)) ? CWT * TD : 0);
  endfunction

  // Pulse monitor: logs each E pulse payload and rise cycle, checks width and bus stability under E
  always @(negedge clk) begin
    if (!rst) begin
      if (lcd_e && !prev_e) begin
        got_q.push_back({lcd_rs, lcd_data});
        rise_q.push_back(cyc);
      end
      if (!lcd_e && prev_e) chk("e_width", hi, TD);
      if ({lcd_rs, lcd_data} !== prev_bus) chk("bus_change_outside_e", {lcd_e, prev_e}, 2'b00);
    end
    hi = lcd_e ? hi + 1 : 0;
    prev_e = lcd_e;
    prev_bus = {lcd_rs, lcd_data};
  end

  task automatic do_write(input logic rs, input logic [7:0] d, input bit keep, output int acc);
    int w, lat;
    cmd_rs = rs;
    cmd_data = d;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait_bounded", w < 200, 1'b1);
    @(negedge clk);
    acc = cyc;
    if (!keep) cmd_valid = 1'b0;
    chk("bus_after_accept", {cmd_ready, lcd_e, lcd_rs, lcd_data}, {1'b0, 1'b0, rs, d});
    lat = 0;
    while (!cmd_ready && lat < 200) begin
      @(negedge clk);
      lat = cyc - acc;
    end
    chk("ready_latency", lat, exp_lat(rs, d));
    chk("pulse_present", got_q.size() > 0, 1'b1);
    if (got_q.size() > 0) begin
      chk("pulse_byte", got_q.pop_front(), {rs, d});
      chk("e_rise_delay", rise_q.pop_front() - acc, TD);
    end
  endtask

  task automatic wait_init(input int t0);
    int k;
    k = 0;
    while (!init_done && k < 400) begin
      @(negedge clk);
      k = cyc - t0;
    end
    chk("init_done_time", k, INIT_T);
    chk("ready_at_init_done", cmd_ready, 1'b1);
  endtask

  initial begin
    int t0, a1, a2, n;
    logic r;
    logic [7:0] d;
    cmd_valid = 1'b1;
    cmd_rs = 1'b1;
    cmd_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data}, 0);
    rst = 1'b0;
    t0 = cyc;
    wait_init(t0);
    chk("init_pulse_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > 0) begin
        chk("init_byte", got_q.pop_front(), {1'b0, init_bytes[i]});
        chk("init_rise_cycle", rise_q.pop_front() - t0, P * TD + TD + 3 * TD * i);
      end
    end
    do_write(1'b1, 8'h55, 1'b0, a1);
    chk("held_request_accept_cycle", a1 - t0, INIT_T + 1);
    do_write(1'b1, 8'h41, 1'b0, a1);
    do_write(1'b0, 8'h01, 1'b0, a1);
    do_write(1'b0, 8'h80, 1'b0, a1);
    do_write(1'b0, 8'h02, 1'b0, a1);
    do_write(1'b1, 8'h48, 1'b1, a1);
    do_write(1'b1, 8'h49, 1'b0, a2);
    chk("back_to_back_gap", a2 - a1, exp_lat(1'b1, 8'h48) + 1);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      do_write(r, d, 1'b0, a1);
    end
    cmd_rs = 1'b1;
    cmd_data = 8'h5A;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!lcd_e && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("e_high_before_reset", lcd_e, 1'b1);
    #1 rst = 1'b1;
    #1 chk("async_reset_outputs", {cmd_ready, init_done, lcd_e, lcd_rs, lcd_data}, 0);
    got_q.delete();
    rise_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    n = 0;
    while (got_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("restart_pulse_present", got_q.size() > 0, 1'b1);
    if (got_q.size() > 0) begin
      chk("restart_first_byte", got_q[0], {1'b0, 8'h38});
      chk("restart_rise_cycle", rise_q[0] - t0, P * TD + TD);
    end
    wait_init(t0);
    chk("restart_pulse_count", got_q.size(), 4);
    got_q.delete();
    rise_q.delete();
    do_write(1'b1, 8'h7E, 1'b0, a1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
